// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative multiply/divide sequencer owning the MIPS HI/LO registers.
//   A mult/multu runs a WIDTH-iteration radix-2 shift-add multiply. A div/divu
//   runs a WIDTH-iteration restoring divide. Both work on operand magnitudes;
//   a final FIX cycle applies sign correction and writes HI/LO.
//
// Ports
//   clk, reset      core clock, asynchronous active-high reset
//   start, op       operation request (0 multu, 1 mult, 2 divu, 3 div)
//   srca, srcb      rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   mf              mfhi/mflo in decode
//   mt_hi, mt_lo    mthi/mtlo write requests, data on wd
//   hi, lo          architectural HI/LO registers
//   busy            operation in flight
//   stall           core must hold PC and instruction
//   done            one-cycle pulse when HI/LO take a result
//   dz              sticky divide-by-zero flag, cleared by the next start
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mf,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   raw_q;
  logic               isDiv_q;
  logic               negRes_q;
  logic               negRem_q;
  logic               dz_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signA, signB;
  logic [WIDTH-1:0]   magA, magB;

  logic [WIDTH:0]     mulUpper;
  logic [2*WIDTH:0]   mulNext;
  logic [2*WIDTH:0]   divShift;
  logic [WIDTH+1:0]   divTrial;
  logic [2*WIDTH:0]   divNext;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]   quoS, remS;
  logic [WIDTH-1:0]   resHi, resLo;

  // Unsigned ops see both operands as non-negative, so one path serves all.
  assign signA = op[0] & srca[WIDTH-1];
  assign signB = op[0] & srcb[WIDTH-1];
  assign magA  = signA ? -srca : srca;
  assign magB  = signB ? -srcb : srcb;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; stall stays combinational so a held request releases the
  // same cycle the sequencer returns to IDLE.
  always_comb begin
    busy  = (state_q != IDLE);
    stall = busy & (start | mf | mt_hi | mt_lo);
    hi    = hi_q;
    lo    = lo_q;
    done  = done_q;
    dz    = dz_q;
  end

  // One iteration of the datapath plus the sign-corrected final result.
  // The multiply add carries into bit 2*WIDTH before the right shift; the
  // divide trial is one bit wider than the shifted remainder so its MSB is
  // the borrow.
  always_comb begin
    mulUpper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mulNext  = acc_q[0] ? {mulUpper, acc_q[WIDTH-1:0]} : acc_q;
    divShift = {acc_q[2*WIDTH-1:0], 1'b0};
    divTrial = {1'b0, divShift[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
    divNext  = divTrial[WIDTH+1] ? divShift
                                 : {divTrial[WIDTH:0], divShift[WIDTH-1:1], 1'b1};
    acc_d    = isDiv_q ? divNext : (mulNext >> 1);

    prodS = negRes_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quoS  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remS  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (isDiv_q && dz_q) begin
      resHi = raw_q;
      resLo = '1;
    end else if (isDiv_q) begin
      resHi = remS;
      resLo = quoS;
    end else begin
      resHi = prodS[2*WIDTH-1:WIDTH];
      resLo = prodS[WIDTH-1:0];
    end
  end

  // Datapath registers. Multiply keeps the multiplier in the low half of the
  // accumulator; divide keeps the dividend there as the quotient shifts in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      raw_q    <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q    <= {{(WIDTH+1){1'b0}}, op[1] ? magA : magB};
            opnd_q   <= op[1] ? magB : magA;
            raw_q    <= srca;
            isDiv_q  <= op[1];
            negRes_q <= signA ^ signB;
            negRem_q <= signA;
            dz_q     <= op[1] & (srcb == '0);
            cnt_q    <= '0;
          end else begin
            if (mt_hi) hi_q <= wd;
            if (mt_lo) lo_q <= wd;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          hi_q <= resHi;
          lo_q <= resLo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
//   Bench for muldiv_seq. A behavioural model tracks HI/LO, busy, done, dz and
//   stall using plain 64-bit arithmetic and a completion countdown; every
//   cycle the DUT outputs are compared against it. Directed operations with
//   hand-computed results pin the model, then randomized traffic follows.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb, wd;
  logic        mf, mt_hi, mt_lo;
  logic [31:0] hi, lo;
  logic        busy, stall, done, dz;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneSeen    = 0;
  int stallSeen   = 0;
  int busySeen    = 0;
  logic lastStall = 1'b0;

  // Model state
  logic [31:0] mHi, mLo;
  logic        mBusy, mDone, mDz;
  int          mRem;
  logic [63:0] mPend;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mf    (mf),
    .mt_hi (mt_hi),
    .mt_lo (mt_lo),
    .wd    (wd),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result {hi, lo} of one operation.
  function automatic logic [63:0] refResult(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Reference model: an accepted op completes 33 edges later; requests while
  // busy are ignored; mt writes apply only in IDLE without start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mHi   <= 32'b0;
      mLo   <= 32'b0;
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mDz   <= 1'b0;
      mRem  <= 0;
      mPend <= 64'b0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        if (mRem == 1) begin
          mHi   <= mPend[63:32];
          mLo   <= mPend[31:0];
          mDone <= 1'b1;
          mBusy <= 1'b0;
        end
        mRem <= mRem - 1;
      end else if (start) begin
        mPend <= refResult(op, srca, srcb);
        mDz   <= op[1] && (srcb == 32'b0);
        mBusy <= 1'b1;
        mRem  <= 33;
      end else begin
        if (mt_hi) mHi <= wd;
        if (mt_lo) mLo <= wd;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compareCycle();
    logic expStall;
    expStall = mBusy & (start | mf | mt_hi | mt_lo);
    checkOutput("hi",    hi,             mHi);
    checkOutput("lo",    lo,             mLo);
    checkOutput("busy",  {31'b0, busy},  {31'b0, mBusy});
    checkOutput("done",  {31'b0, done},  {31'b0, mDone});
    checkOutput("dz",    {31'b0, dz},    {31'b0, mDz});
    checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
    lastStall = expStall;
    doneSeen  += int'(done);
    stallSeen += int'(stall);
    busySeen  += int'(busy);
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for one cycle from IDLE.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    step();
    start = 1'b0;
  endtask

  // Run one full operation and pin its result against literal values.
  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(o, a, b);
    doneSeen = 0;
    busySeen = 0;
    repeat (34) step();
    checkOutput({name, "_hi"},    hi,                  expHi);
    checkOutput({name, "_lo"},    lo,                  expLo);
    checkOutput({name, "_done"},  doneSeen,            32'd1);
    checkOutput({name, "_busy"},  busySeen,            32'd33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    srca  = 32'b0;
    srcb  = 32'b0;
    wd    = 32'b0;
    mf    = 1'b0;
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    checkOutput("rst_hi",   hi,             32'h0);
    checkOutput("rst_lo",   lo,             32'h0);
    checkOutput("rst_busy", {31'b0, busy},  32'h0);
    checkOutput("rst_dz",   {31'b0, dz},    32'h0);

    // Directed operations with hand-computed results
    runOp("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult_neg",  2'd1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("div_neg",   2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu_zero", 2'd2, 32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF);
    checkOutput("dz_set", {31'b0, dz}, 32'h1);
    runOp("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    checkOutput("dz_clr", {31'b0, dz}, 32'h0);

    // mf raised on the fifth cycle of a divide stalls until the result lands
    applyStimulus(2'd2, 32'd1000, 32'd7);
    repeat (4) step();
    mf = 1'b1;
    stallSeen = 0;
    guard = 0;
    do begin
      step();
      guard++;
    end while (lastStall && guard < 60);
    checkOutput("mf_stall_cycles", stallSeen, 32'd29);
    checkOutput("mf_hi", hi, 32'd6);
    checkOutput("mf_lo", lo, 32'd142);
    mf = 1'b0;

    // mthi in IDLE lands on the next edge
    mt_hi = 1'b1;
    wd    = 32'h0000_1234;
    step();
    mt_hi = 1'b0;
    checkOutput("mthi", hi, 32'h0000_1234);

    // mtlo issued during CALC is held and lands after the result
    applyStimulus(2'd0, 32'h0001_0000, 32'h0003_0000);
    repeat (3) step();
    mt_lo = 1'b1;
    wd    = 32'h0000_CAFE;
    guard = 0;
    do begin
      step();
      guard++;
    end while (lastStall && guard < 60);
    mt_lo = 1'b0;
    checkOutput("mtlo_lo", lo, 32'h0000_CAFE);
    checkOutput("mtlo_hi", hi, 32'h0000_0003);

    // Reset in the middle of a multiply discards it
    applyStimulus(2'd1, 32'hFFFF_FFFB, 32'd9);
    repeat (9) step();
    reset = 1'b1;
    step();
    checkOutput("midrst_hi",   hi,            32'h0);
    checkOutput("midrst_lo",   lo,            32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    doneSeen = 0;
    repeat (40) step();
    checkOutput("midrst_nodone", doneSeen, 32'd0);
    runOp("after_rst", 2'd0, 32'd6, 32'd7, 32'h0, 32'd42);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 11) == 0);
      op    = 2'($urandom_range(0, 3));
      srca  = pick();
      srcb  = pick();
      mf    = ($urandom_range(0, 3) == 0);
      mt_hi = ($urandom_range(0, 9) == 0);
      mt_lo = ($urandom_range(0, 9) == 0);
      wd    = $urandom;
      step();
    end
    start = 1'b0;
    mf    = 1'b0;
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
